jtbubl_sndcomm: RTL and testbench
=================================

JTBUBL_SNDCOMM -- requirements
Module: jtbubl_sndcomm

Interface
REQ-001 SHALL have port `clk24`, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port `cen6`, input, 1 bit: clock enable used only for reset-stretch timing.
REQ-004 SHALL have port `main_latch_we`, input, 1 bit: one-clk24 pulse; main CPU writes the sound latch.
REQ-005 SHALL have port `main_rst_we`, input, 1 bit: one-clk24 pulse; main CPU writes the sound-reset request from `main_din[0]`.
REQ-006 SHALL have port `main_reply_rd`, input, 1 bit: one-clk24 pulse; main CPU reads the reply latch.
REQ-007 SHALL have port `main_stat_rd`, input, 1 bit: one-clk24 pulse; main CPU reads status.
REQ-008 SHALL have port `main_din`, input, 8 bits: main CPU write data.
REQ-009 SHALL have port `main_reply`, output, 8 bits: reply byte.
REQ-010 SHALL have port `main_status`, output, 8 bits: {5'b0, overrun, reply_full, latch_full}.
REQ-011 SHALL have port `snd_latch`, output, 8 bits: command byte presented to the sound CPU.
REQ-012 SHALL have ports `snd_latch_rd` (input, 1 bit), `snd_reply_we` (input, 1 bit), `snd_nmi_en_we` (input, 1 bit) and `snd_din` (input, 8 bits): sound-CPU one-clk24 strobes and data.
REQ-013 SHALL have port `snd_nmi_n`, output, 1 bit: NMI to the sound CPU, active-low.
REQ-014 SHALL have port `snd_rst`, output, 1 bit: sound CPU reset, active-high.
REQ-015 SHALL have parameter `RSTLEN`, default 16: minimum `snd_rst` high time, counted in cen6 ticks.

Function
REQ-016 SHALL, on `main_latch_we`, load `main_din` into `snd_latch` and set latch_full, both visible on the next clk24 cycle.
REQ-017 SHALL, when `main_latch_we` occurs while latch_full=1, set sticky overrun and overwrite `snd_latch`.
REQ-018 SHALL clear latch_full on `snd_latch_rd`.
REQ-019 SHALL, when `main_latch_we` and `snd_latch_rd` coincide, let the write win: latch_full=1 and `snd_latch` takes the new byte.
REQ-020 SHALL clear overrun on `main_stat_rd`; a coincident overrun-setting write SHALL take priority, leaving overrun=1.
REQ-021 SHALL, on `snd_reply_we`, load `snd_din` into `main_reply` and set reply_full; `main_reply_rd` SHALL clear reply_full, and on coincidence the write SHALL win.
REQ-022 SHALL, on `snd_nmi_en_we`, set nmi_en to `snd_din[0]`.
REQ-023 SHALL drive `snd_nmi_n` = ~(latch_full & nmi_en) from registers, with no combinational path from the inputs.
REQ-024 SHALL implement the reset-stretch FSM with states IDLE, HOLD and WAITREL; `snd_rst` SHALL be 1 in HOLD and WAITREL.
REQ-025 SHALL use these FSM transitions:
- IDLE -> HOLD on `main_rst_we` with `main_din[0]`=1, loading the counter with RSTLEN-1.
- HOLD decrements the counter on each cen6; HOLD -> WAITREL when the counter is 0 on a cen6.
- WAITREL -> IDLE once the request bit is 0; in WAITREL a request=0 already written releases on the next clk24 cycle.
- A write of request=0 during HOLD SHALL be recorded and SHALL NOT shorten HOLD.
- A write of request=1 during HOLD or WAITREL SHALL NOT restart the counter.
REQ-026 SHALL use a counter width of clog2(RSTLEN); it SHALL saturate at 0 and never wrap.
REQ-027 SHALL, while `snd_rst`=1, hold reply_full=0 and nmi_en=1 and ignore `snd_*` strobes; `snd_latch`, latch_full and overrun SHALL be preserved.

Reset
REQ-028 SHALL, with `rst_n`=0, asynchronously set `snd_latch`=0, `main_reply`=0, latch_full=0, reply_full=0, overrun=0, nmi_en=1, FSM=HOLD with the counter at RSTLEN-1 and the request bit at 0.
REQ-029 SHALL therefore drive `snd_nmi_n`=1 and `snd_rst`=1 out of reset, and release `snd_rst` RSTLEN cen6 ticks after `rst_n` rises.
REQ-030 SHALL, when `rst_n` is asserted mid-operation, abandon any pending handshake; no strobe SHALL be remembered across reset.

Structure
REQ-031 SHALL place the FSM state encoding (2 bits), the status bit positions and the RSTLEN default in the shared package `jtbubl_pkg`.
REQ-032 SHALL implement the reset-stretch FSM as the single sub-module `jtbubl_rststretch` (ports `clk24`, `rst_n`, `cen6`, `req_we`, `req`, `rst_out`).
REQ-033 SHALL keep the latch/flag logic in the top level, with no further hierarchy.

Verification
REQ-034 SHALL cover: `main_latch_we` with 8'h5A -> `snd_latch`=8'h5A, `main_status`=8'h01, `snd_nmi_n`=0 the next cycle; `snd_latch_rd` -> `snd_nmi_n`=1.
REQ-035 SHALL cover: two writes, 8'h11 then 8'h22, with no read -> `snd_latch`=8'h22, `main_status`=8'h05; `main_stat_rd` -> 8'h01.
REQ-036 SHALL cover: `main_latch_we` 8'h33 coincident with `snd_latch_rd` -> latch_full stays 1 and `snd_latch`=8'h33.
REQ-037 SHALL cover: `snd_nmi_en_we` with `snd_din`=0, then a latch write -> `snd_nmi_n` stays 1; re-enable -> `snd_nmi_n`=0 immediately after.
REQ-038 SHALL cover: request=1 then request=0 three cen6 ticks later (RSTLEN=16) -> `snd_rst` high for exactly 16 cen6 ticks, reply_full=0 throughout.
REQ-039 SHALL cover: `rst_n` pulsed low while latch_full=1 and the FSM is in WAITREL -> all flags 0, `snd_rst`=1, release after 16 cen6 ticks.

Source files
------------

// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble sound-CPU communication block.
package jtbubl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_WAITREL = 2'd2
  } rst_st_e;

  localparam int STAT_LATCH = 0;
  localparam int STAT_REPLY = 1;
  localparam int STAT_OVR   = 2;

  localparam int RSTLEN_DEF = 16;
endpackage

// File: rtl/jtbubl_rststretch.sv
// Sound-CPU reset stretcher: holds rst_out for RSTLEN cen6 ticks, then waits for the request to drop.
module jtbubl_rststretch
  import jtbubl_pkg::*;
#(
  parameter int RSTLEN = RSTLEN_DEF
) (
  input  logic clk24,
  input  logic rst_n,
  input  logic cen6,
  input  logic req_we,
  input  logic req,
  output logic rst_out
);
  localparam int CW = (RSTLEN > 1) ? $clog2(RSTLEN) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RSTLEN - 1);

  rst_st_e st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic rq, rq_nx;

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_HOLD;
      cnt <= CNT_INIT;
      rq  <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      rq  <= rq_nx;
    end
  end

  // The request bit is always recorded, but only IDLE reacts to a new 1,
  // so repeated requests never restart an ongoing hold.
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    rq_nx  = req_we ? req : rq;
    case (st)
      ST_IDLE: begin
        if (req_we && req) begin
          st_nx  = ST_HOLD;
          cnt_nx = CNT_INIT;
        end
      end
      ST_HOLD: begin
        if (cen6) begin
          if (cnt == '0) st_nx = ST_WAITREL;
          else           cnt_nx = cnt - CW'(1);
        end
      end
      ST_WAITREL: begin
        if (!rq) st_nx = ST_IDLE;
      end
      default: st_nx = ST_HOLD;
    endcase
  end

  assign rst_out = (st != ST_IDLE);
endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main/sound CPU mailbox: command latch, reply latch, status flags, NMI and sound reset.
module jtbubl_sndcomm
  import jtbubl_pkg::*;
#(
  parameter int RSTLEN = RSTLEN_DEF
) (
  input  logic       clk24,
  input  logic       rst_n,
  input  logic       cen6,
  input  logic       main_latch_we,
  input  logic       main_rst_we,
  input  logic       main_reply_rd,
  input  logic       main_stat_rd,
  input  logic [7:0] main_din,
  output logic [7:0] main_reply,
  output logic [7:0] main_status,
  output logic [7:0] snd_latch,
  input  logic       snd_latch_rd,
  input  logic       snd_reply_we,
  input  logic       snd_nmi_en_we,
  input  logic [7:0] snd_din,
  output logic       snd_nmi_n,
  output logic       snd_rst
);
  logic latch_full, reply_full, overrun, nmi_en;

  jtbubl_rststretch #(.RSTLEN(RSTLEN)) u_rst (
    .clk24  (clk24),
    .rst_n  (rst_n),
    .cen6   (cen6),
    .req_we (main_rst_we),
    .req    (main_din[0]),
    .rst_out(snd_rst)
  );

  // Main-side writes are accepted even while the sound CPU is in reset.
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      snd_latch  <= 8'd0;
      latch_full <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (main_latch_we) begin
        snd_latch  <= main_din;
        latch_full <= 1'b1;
      end else if (snd_latch_rd && !snd_rst) begin
        latch_full <= 1'b0;
      end
      if (main_latch_we && latch_full) overrun <= 1'b1;
      else if (main_stat_rd)           overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      main_reply <= 8'd0;
      reply_full <= 1'b0;
      nmi_en     <= 1'b1;
    end else if (snd_rst) begin
      reply_full <= 1'b0;
      nmi_en     <= 1'b1;
    end else begin
      if (snd_reply_we) begin
        main_reply <= snd_din;
        reply_full <= 1'b1;
      end else if (main_reply_rd) begin
        reply_full <= 1'b0;
      end
      if (snd_nmi_en_we) nmi_en <= snd_din[0];
    end
  end

  // Masking with snd_rst hides a stale reply_full during the first reset cycle.
  always_comb begin
    main_status             = 8'd0;
    main_status[STAT_LATCH] = latch_full;
    main_status[STAT_REPLY] = reply_full & ~snd_rst;
    main_status[STAT_OVR]   = overrun;
  end

  assign snd_nmi_n = ~(latch_full & nmi_en);
endmodule

// File: tb/tb_jtbubl_sndcomm.sv
// Directed bench for jtbubl_sndcomm: mailbox flags, NMI gating and reset stretch.
module tb_jtbubl_sndcomm;
  logic       clk24 = 1'b0, rst_n = 1'b0, cen6 = 1'b0;
  logic       main_latch_we = 1'b0, main_rst_we = 1'b0, main_reply_rd = 1'b0, main_stat_rd = 1'b0;
  logic [7:0] main_din = 8'd0, snd_din = 8'd0;
  logic       snd_latch_rd = 1'b0, snd_reply_we = 1'b0, snd_nmi_en_we = 1'b0;
  logic [7:0] main_reply, main_status, snd_latch;
  logic       snd_nmi_n, snd_rst;

  int errs = 0, checks = 0, ticks = 0, reply_bad = 0, cdiv = 0;

  jtbubl_sndcomm #(.RSTLEN(16)) dut (
    .clk24(clk24), .rst_n(rst_n), .cen6(cen6),
    .main_latch_we(main_latch_we), .main_rst_we(main_rst_we),
    .main_reply_rd(main_reply_rd), .main_stat_rd(main_stat_rd),
    .main_din(main_din), .main_reply(main_reply), .main_status(main_status),
    .snd_latch(snd_latch), .snd_latch_rd(snd_latch_rd), .snd_reply_we(snd_reply_we),
    .snd_nmi_en_we(snd_nmi_en_we), .snd_din(snd_din),
    .snd_nmi_n(snd_nmi_n), .snd_rst(snd_rst)
  );

  always #5 clk24 = ~clk24;

  // cen6 = one clk24 in four, changed 1 ns after the edge
  always begin
    @(posedge clk24);
    #1;
    cdiv = (cdiv + 1) % 4;
    cen6 = (cdiv == 0);
  end

  task automatic tick();
    if (cen6 && snd_rst && rst_n) ticks++;
    @(posedge clk24);
    #2;
    if (snd_rst && main_status[1]) reply_bad++;
  endtask

  task automatic clr();
    main_latch_we = 1'b0; main_rst_we = 1'b0; main_reply_rd = 1'b0; main_stat_rd = 1'b0;
    snd_latch_rd = 1'b0; snd_reply_we = 1'b0; snd_nmi_en_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rel(input int lim);
    for (int n = 0; n < lim && snd_rst; n++) tick();
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_latch", snd_latch, 8'h00);
    chk("rst_reply", main_reply, 8'h00);
    chk("rst_status", main_status, 8'h00);
    chk("rst_nmi", {7'd0, snd_nmi_n}, 8'h01);
    chk("rst_sndrst", {7'd0, snd_rst}, 8'h01);
    rst_n = 1'b1; ticks = 0;
    wait_rel(300);
    chk("por_ticks", ticks[7:0], 8'd16);
    chk("por_rel", {7'd0, snd_rst}, 8'h00);

    // single command, then sound read
    main_latch_we = 1'b1; main_din = 8'h5A; tick(); clr();
    chk("w5a_latch", snd_latch, 8'h5A);
    chk("w5a_status", main_status, 8'h01);
    chk("w5a_nmi", {7'd0, snd_nmi_n}, 8'h00);
    snd_latch_rd = 1'b1; tick(); clr();
    chk("rd_nmi", {7'd0, snd_nmi_n}, 8'h01);
    chk("rd_status", main_status, 8'h00);

    // overrun
    main_latch_we = 1'b1; main_din = 8'h11; tick();
    main_din = 8'h22; tick(); clr();
    chk("ovr_latch", snd_latch, 8'h22);
    chk("ovr_status", main_status, 8'h05);
    main_stat_rd = 1'b1; tick(); clr();
    chk("ovr_clr", main_status, 8'h01);
    snd_latch_rd = 1'b1; tick(); clr();

    // write and read coincide
    main_latch_we = 1'b1; main_din = 8'h33; snd_latch_rd = 1'b1; tick(); clr();
    chk("coin_latch", snd_latch, 8'h33);
    chk("coin_status", main_status, 8'h01);
    // overrun-setting write beats status read
    main_latch_we = 1'b1; main_din = 8'h44; main_stat_rd = 1'b1; tick(); clr();
    chk("ovr_prio", main_status, 8'h05);
    main_stat_rd = 1'b1; snd_latch_rd = 1'b1; tick(); clr();
    chk("ovr_prio_clr", main_status, 8'h00);

    // reply path
    snd_reply_we = 1'b1; snd_din = 8'hA5; tick(); clr();
    chk("rep_data", main_reply, 8'hA5);
    chk("rep_status", main_status, 8'h02);
    snd_reply_we = 1'b1; snd_din = 8'h3C; main_reply_rd = 1'b1; tick(); clr();
    chk("rep_coin", main_reply, 8'h3C);
    chk("rep_coin_st", main_status, 8'h02);
    main_reply_rd = 1'b1; tick(); clr();
    chk("rep_rd", main_status, 8'h00);

    // NMI enable
    snd_nmi_en_we = 1'b1; snd_din = 8'h00; tick(); clr();
    main_latch_we = 1'b1; main_din = 8'h77; tick(); clr();
    chk("nmi_off", {7'd0, snd_nmi_n}, 8'h01);
    snd_nmi_en_we = 1'b1; snd_din = 8'h01; tick(); clr();
    chk("nmi_on", {7'd0, snd_nmi_n}, 8'h00);
    snd_latch_rd = 1'b1; tick(); clr();

    // reset stretch with early release request
    snd_reply_we = 1'b1; snd_din = 8'h99; tick(); clr();
    main_latch_we = 1'b1; main_din = 8'h66; tick(); clr();
    chk("pre_status", main_status, 8'h03);
    ticks = 0; reply_bad = 0;
    main_rst_we = 1'b1; main_din = 8'h01; tick(); clr();
    chk("hold_on", {7'd0, snd_rst}, 8'h01);
    chk("hold_status", main_status, 8'h01);
    snd_reply_we = 1'b1; snd_din = 8'h12; snd_latch_rd = 1'b1; snd_nmi_en_we = 1'b1; tick(); clr();
    for (int n = 0; n < 100 && ticks < 3; n++) tick();
    main_rst_we = 1'b1; main_din = 8'h00; tick(); clr();
    wait_rel(300);
    chk("hold_ticks", ticks[7:0], 8'd16);
    chk("hold_rel", {7'd0, snd_rst}, 8'h00);
    chk("hold_reply0", reply_bad[7:0], 8'd0);
    chk("hold_keep", main_status, 8'h01);
    chk("hold_latch", snd_latch, 8'h66);
    chk("hold_nmi", {7'd0, snd_nmi_n}, 8'h00);

    // async reset while in WAITREL with a full latch
    ticks = 0;
    main_rst_we = 1'b1; main_din = 8'h01; tick(); clr();
    for (int n = 0; n < 300 && ticks < 16; n++) tick();
    for (int n = 0; n < 8; n++) tick();
    chk("wr_held", {7'd0, snd_rst}, 8'h01);
    main_latch_we = 1'b1; main_din = 8'hAA; tick(); clr();
    chk("wr_status", main_status, 8'h05);
    rst_n = 1'b0; #1;
    chk("ar_status", main_status, 8'h00);
    chk("ar_latch", snd_latch, 8'h00);
    chk("ar_nmi", {7'd0, snd_nmi_n}, 8'h01);
    chk("ar_sndrst", {7'd0, snd_rst}, 8'h01);
    tick(); tick();
    rst_n = 1'b1; ticks = 0;
    wait_rel(300);
    chk("ar_ticks", ticks[7:0], 8'd16);
    chk("ar_rel", {7'd0, snd_rst}, 8'h00);
    chk("ar_final", main_status, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
